// File: rtl/clkdiv_monitor_pkg.sv
// Shared definitions for the clkdiv receive-side monitor:
// lock FSM encoding, synchronizer depth and the lock threshold.
package clkdiv_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } lock_state_e;

    localparam int SYNC_DEPTH = 2;

    // Consecutive in-tolerance halves needed in ACQ before declaring lock.
    localparam logic [1:0] GOOD_TO_LOCK = 2'd2;

endpackage

// File: rtl/clkdiv_monitor_sync_edge.sv
// Brings the asynchronous slow square wave into the clk domain and emits
// registered one-cycle rise/fall strobes (three clk edges after the input moves).
module clkdiv_monitor_sync_edge
    import clkdiv_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic                  synced;

    assign synced = sync_q[SYNC_DEPTH-1];

    // NOTE: non-blocking assignments so every flop samples the pre-edge value;
    // blocking here would collapse the synchronizer chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_DEPTH-2:0], din};
            prev_q     <= synced;
            rise_pulse <= synced & ~prev_q;
            fall_pulse <= ~synced & prev_q;
        end
    end

endmodule

// File: rtl/clkdiv_monitor.sv
// Receive-side checker for the clkdiv square wave: edge strobes, half/full
// period measurement and an IDLE/ACQ/LOCKED/LOST lock tracker.
module clkdiv_monitor
    import clkdiv_monitor_pkg::*;
#(
    parameter int EXP_HALF = 50001,
    parameter int TOL      = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] HALF_MIN = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] HALF_TMO = CNT_W'(EXP_HALF + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] pcnt;
    logic [1:0]       good;
    logic             rise_seen;
    lock_state_e      state;

    logic any_edge;
    logic half_ok;
    logic timeout;

    clkdiv_monitor_sync_edge u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .din        (clk_div_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // hcnt equals the length of the half that ends on this cycle's strobe.
    assign any_edge = rise_pulse | fall_pulse;
    assign half_ok  = (hcnt >= HALF_MIN) && (hcnt <= HALF_MAX);
    assign timeout  = !any_edge && (hcnt == HALF_TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            pcnt <= '0;
        end else begin
            hcnt <= any_edge   ? CNT_ONE : ((hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE);
            pcnt <= rise_pulse ? CNT_ONE : ((pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            good         <= 2'd0;
            rise_seen    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            locked       <= (state == ST_LOCKED);
            lost         <= (state == ST_LOST);
            period_valid <= 1'b0;

            // A full period is only trusted once a rise has been seen while tracking.
            if (rise_pulse && rise_seen && (state == ST_ACQ || state == ST_LOCKED)) begin
                period       <= pcnt;
                period_valid <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_LOST: begin
                    rise_seen <= rise_pulse;
                    if (any_edge) begin
                        state <= ST_ACQ;
                        good  <= 2'd0;
                    end
                end
                ST_ACQ: begin
                    if (any_edge) begin
                        if (rise_pulse)
                            rise_seen <= 1'b1;
                        if (!half_ok) begin
                            good <= 2'd0;
                        end else if (good == GOOD_TO_LOCK - 2'd1) begin
                            state <= ST_LOCKED;
                            good  <= 2'd0;
                        end else begin
                            good <= good + 2'd1;
                        end
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        good      <= 2'd0;
                        rise_seen <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if ((any_edge && !half_ok) || timeout) begin
                        state     <= ST_LOST;
                        rise_seen <= 1'b0;
                    end else if (rise_pulse) begin
                        rise_seen <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    good      <= 2'd0;
                    rise_seen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Self-checking bench for clkdiv_monitor with EXP_HALF=5, TOL=1: a table of
// half-period records drives the input; expectations are queued and compared on each strobe.
module tb_clkdiv_monitor;

    localparam int EXP_HALF = 5;
    localparam int TOL      = 1;
    localparam int CNT_W    = 16;
    localparam int N_VEC    = 28;
    localparam int RST_AT   = 22;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_div_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;

    always #5 clk = ~clk;

    clkdiv_monitor #(
        .EXP_HALF (EXP_HALF),
        .TOL      (TOL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_div_in   (clk_div_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    // One record per input toggle: the half that follows it and what the DUT
    // must report for the edge it creates.
    typedef struct {
        int len;
        bit rise;
        bit pv;
        int per;
        bit lk;
        bit ls;
        int probe_off;
        bit probe_lk;
        bit probe_ls;
    } vec_t;

    typedef struct {
        int   t;
        vec_t v;
    } exp_t;

    vec_t vecs [N_VEC];
    exp_t sb [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pv_cyc = -1, lk_cyc = -1, pr_cyc = -1;
    int last_period = 0;
    vec_t pend_pv, pend_lk, pend_pr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int len, input bit rise, input bit pv, input int per,
                           input bit lk, input bit ls, input int poff, input bit plk, input bit pls);
        vecs[i] = '{len, rise, pv, per, lk, ls, poff, plk, pls};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"},   rise_pulse,   0);
        check({tag, "_fall"},   fall_pulse,   0);
        check({tag, "_pv"},     period_valid, 0);
        check({tag, "_period"}, period,       0);
        check({tag, "_locked"}, locked,       0);
        check({tag, "_lost"},   lost,         0);
    endtask

    // Per-cycle scoreboard step, sampled on the falling edge.
    task automatic monitor_step();
        exp_t e;
        if (rst) begin
            pv_cyc = -1;
            lk_cyc = -1;
            pr_cyc = -1;
            last_period = 0;
            return;
        end
        if (rise_pulse || fall_pulse) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {62'd0, rise_pulse, fall_pulse}, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_rise",    rise_pulse, e.v.rise);
                check("strobe_fall",    fall_pulse, !e.v.rise);
                check("strobe_latency", cyc - e.t,  3);
                pv_cyc  = cyc + 1;
                pend_pv = e.v;
                lk_cyc  = cyc + 2;
                pend_lk = e.v;
                if (e.v.probe_off > 0) begin
                    pr_cyc  = cyc + e.v.probe_off;
                    pend_pr = e.v;
                end
            end
        end
        if (cyc == pv_cyc) begin
            check("period_valid", period_valid, pend_pv.pv);
            if (pend_pv.pv)
                last_period = pend_pv.per;
            check("period", period, last_period);
            pv_cyc = -1;
        end else if (period_valid) begin
            check("stray_period_valid", period_valid, 0);
        end
        if (cyc == lk_cyc) begin
            check("locked", locked, pend_lk.lk);
            check("lost",   lost,   pend_lk.ls);
            lk_cyc = -1;
        end
        if (cyc == pr_cyc) begin
            check("timeout_locked", locked, pend_pr.probe_lk);
            check("timeout_lost",   lost,   pend_pr.probe_ls);
            pr_cyc = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor_step();
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        clk_div_in = v.rise;
        e.t = cyc;
        e.v = v;
        sb.push_back(e);
        repeat (v.len) tick();
    endtask

    initial begin
        //            len rise pv per lk ls probe lk ls
        set_vec( 0,   5, 1, 0,  0, 0, 0, 0, 0, 0);  // IDLE -> ACQ
        set_vec( 1,   5, 0, 0,  0, 0, 0, 0, 0, 0);
        set_vec( 2,   5, 1, 1, 10, 1, 0, 0, 0, 0);  // second good half -> LOCKED
        set_vec( 3,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec( 4,   5, 1, 1, 10, 1, 0, 0, 0, 0);
        set_vec( 5,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec( 6,   4, 1, 1, 10, 1, 0, 0, 0, 0);  // tolerance edges 4 and 6
        set_vec( 7,   6, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec( 8,   5, 1, 1, 10, 1, 0, 0, 0, 0);
        set_vec( 9,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec(10,   8, 1, 1, 10, 1, 0, 9, 0, 1);  // stretched half -> timeout
        set_vec(11,   5, 0, 0,  0, 0, 0, 0, 0, 0);  // LOST -> ACQ, not judged
        set_vec(12,   5, 1, 0,  0, 0, 0, 0, 0, 0);  // no prior rise since LOST
        set_vec(13,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec(14,   5, 1, 1, 10, 1, 0, 0, 0, 0);
        set_vec(15,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec(16,   3, 1, 1, 10, 1, 0, 0, 0, 0);  // short half follows
        set_vec(17,   5, 0, 0,  0, 0, 1, 0, 0, 0);  // 3-cycle half -> LOST
        set_vec(18,   5, 1, 0,  0, 0, 0, 0, 0, 0);
        set_vec(19,   5, 0, 0,  0, 0, 0, 0, 0, 0);
        set_vec(20,   5, 1, 1, 10, 1, 0, 0, 0, 0);
        set_vec(21,   5, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec(22,   5, 1, 0,  0, 0, 0, 0, 0, 0);  // after reset: IDLE -> ACQ
        set_vec(23,   5, 0, 0,  0, 0, 0, 0, 0, 0);
        set_vec(24,   5, 1, 1, 10, 1, 0, 0, 0, 0);
        set_vec(25,   6, 0, 0,  0, 1, 0, 0, 0, 0);
        set_vec(26,   5, 1, 1, 11, 1, 0, 0, 0, 0);
        set_vec(27,  12, 0, 0,  0, 1, 0, 9, 0, 1);  // input stops -> timeout

        rst        = 1'b1;
        clk_div_in = 1'b0;
        tick();
        tick();
        check_all_zero("in_reset");
        #2 rst = 1'b0;

        // Constant input: the monitor must stay idle.
        for (int k = 0; k < 10; k++) begin
            repeat (10) tick();
            check("idle_locked", locked,       0);
            check("idle_lost",   lost,         0);
            check("idle_pv",     period_valid, 0);
            check("idle_period", period,       0);
        end

        for (int i = 0; i < RST_AT; i++)
            apply(vecs[i]);

        // Asynchronous reset while locked.
        repeat (3) tick();
        check("pre_reset_locked", locked, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        tick();
        #2 rst = 1'b0;
        tick();

        for (int i = RST_AT; i < N_VEC; i++)
            apply(vecs[i]);

        repeat (4) tick();
        check("scoreboard_empty", sb.size(), 0);
        check("probe_done",       pr_cyc,    -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
